// File: rtl/seq_gen_scheduler_if.sv
// Request/grant and sequence-observation bundle for seq_gen_scheduler.
// Requesters drive req/steps/clear and watch done to drop req; the scheduler drives the rest.
interface seq_gen_scheduler_if #(parameter int CNT_W = 3);
  logic [1:0]       req;
  logic [CNT_W-1:0] steps0;
  logic [CNT_W-1:0] steps1;
  logic             clear;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic [3:0]       Yt;
  logic [3:0]       Yt1;
  logic [3:0]       t_in;

  modport master (
    output req, steps0, steps1, clear,
    input  gnt, busy, done, Yt, Yt1, t_in
  );

  modport slave (
    input  req, steps0, steps1, clear,
    output gnt, busy, done, Yt, Yt1, t_in
  );
endinterface

// File: rtl/seq_gen_scheduler.sv
// Round-robin two-requester scheduler stepping a T-flip-flop sequence 0-8-5-3-7-2 for N cycles per grant.
// Grant one edge after req in IDLE; N RUN cycles then one DONE cycle; requests are level and ignored while busy.
module seq_gen_scheduler #(
  parameter int CNT_W = 3
) (
  input logic             clock,
  input logic             reset_n,
  seq_gen_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       yt, yt_nxt, yt1, t_vec;
  logic [1:0]       gnt, gnt_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             last, last_nxt;
  logic             win;
  logic [CNT_W-1:0] win_steps;

  // Successor on the legal ring; anything off the ring falls back to 0.
  always_comb begin
    case (yt)
      4'd0:    yt1 = 4'd8;
      4'd8:    yt1 = 4'd5;
      4'd5:    yt1 = 4'd3;
      4'd3:    yt1 = 4'd7;
      4'd7:    yt1 = 4'd2;
      4'd2:    yt1 = 4'd0;
      default: yt1 = 4'd0;
    endcase
  end

  always_comb begin
    win       = bus.req[0] ? (bus.req[1] ? ~last : 1'b0) : 1'b1;
    win_steps = win ? bus.steps1 : bus.steps0;
    t_vec     = (state == RUN) ? (yt ^ yt1) : 4'd0;

    state_nxt = state;
    yt_nxt    = yt;
    gnt_nxt   = gnt;
    rem_nxt   = rem;
    last_nxt  = last;

    case (state)
      IDLE: begin
        if (bus.clear) begin
          yt_nxt = 4'd0;
        end
        if (bus.req != 2'b00) begin
          gnt_nxt   = win ? 2'b10 : 2'b01;
          rem_nxt   = win_steps;
          last_nxt  = win;
          state_nxt = (win_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        yt_nxt  = yt ^ t_vec;
        rem_nxt = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      yt    <= 4'd0;
      gnt   <= 2'b00;
      rem   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      yt    <= yt_nxt;
      gnt   <= gnt_nxt;
      rem   <= rem_nxt;
      last  <= last_nxt;
    end
  end

  assign bus.gnt  = gnt;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.Yt   = yt;
  assign bus.Yt1  = yt1;
  assign bus.t_in = t_vec;

endmodule

// File: tb/tb_seq_gen_scheduler.sv
// Bench for seq_gen_scheduler: transaction-level expected-cycle queue plus literal directed checks.
module tb_seq_gen_scheduler;
  localparam int CNT_W = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  seq_gen_scheduler_if #(.CNT_W(CNT_W)) sif();

  seq_gen_scheduler #(.CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sif)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] succ(input logic [3:0] y);
    logic [3:0] ring [6];
    ring = '{4'd0, 4'd8, 4'd5, 4'd3, 4'd7, 4'd2};
    for (int i = 0; i < 6; i++) begin
      if (ring[i] == y) return ring[(i + 1) % 6];
    end
    return 4'd0;
  endfunction

  // Each grant is expanded into its whole per-cycle output schedule when it is decided.
  typedef struct packed {
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       run;
  } exp_t;

  localparam exp_t IDLE_E = '0;

  exp_t       q[$];
  exp_t       cur    = '0;
  logic [3:0] m_yt   = 4'd0;
  logic       m_last = 1'b1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      cur    = IDLE_E;
      m_yt   = 4'd0;
      m_last = 1'b1;
    end else begin
      if (cur.run) m_yt = succ(m_yt);
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (cur.busy) begin
        cur = IDLE_E;
      end else begin
        if (sif.clear) m_yt = 4'd0;
        if (sif.req != 2'b00) begin
          int   w;
          int   n;
          exp_t e;
          if (sif.req == 2'b11) w = m_last ? 0 : 1;
          else                  w = sif.req[1] ? 1 : 0;
          n      = w ? int'(sif.steps1) : int'(sif.steps0);
          e.gnt  = w ? 2'b10 : 2'b01;
          e.busy = 1'b1;
          e.done = 1'b0;
          e.run  = 1'b1;
          for (int k = 0; k < n; k++) q.push_back(e);
          e.run  = 1'b0;
          e.done = 1'b1;
          q.push_back(e);
          m_last = (w == 1);
          cur    = q.pop_front();
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [3:0] nx;
    nx = succ(m_yt);
    chk("m_gnt",  32'(sif.gnt),  32'(cur.gnt));
    chk("m_busy", 32'(sif.busy), 32'(cur.busy));
    chk("m_done", 32'(sif.done), 32'(cur.done));
    chk("m_Yt",   32'(sif.Yt),   32'(m_yt));
    chk("m_Yt1",  32'(sif.Yt1),  32'(nx));
    chk("m_t_in", 32'(sif.t_in), 32'(cur.run ? (m_yt ^ nx) : 4'd0));
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_in(input logic [1:0] r, input int s0, input int s1, input logic c);
    sif.req    = r;
    sif.steps0 = CNT_W'(s0);
    sif.steps1 = CNT_W'(s1);
    sif.clear  = c;
  endtask

  task automatic do_reset;
    @(negedge clock);
    set_in(2'b00, 0, 0, 1'b0);
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("rst_gnt",  32'(sif.gnt),  32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    chk("rst_Yt",   32'(sif.Yt),   32'd0);
    reset_n = 1'b1;
  endtask

  logic [3:0] a_lit [6];
  logic [1:0] c_gnt [$];
  logic [1:0] r;

  initial begin
    set_in(2'b00, 0, 0, 1'b0);
    #1 reset_n = 1'b0;
    a_lit = '{4'd0, 4'd8, 4'd5, 4'd3, 4'd7, 4'd2};

    // Single requester, six steps round the full ring.
    do_reset();
    set_in(2'b01, 6, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      nclk(1);
      chk("A_Yt", 32'(sif.Yt), 32'(a_lit[k]));
      if (k == 0) chk("A_gnt", 32'(sif.gnt), 32'h1);
    end
    nclk(1);
    chk("A_done", 32'(sif.done), 32'd1);
    chk("A_Yt_end", 32'(sif.Yt), 32'd0);
    set_in(2'b00, 0, 0, 1'b0);
    nclk(1);
    chk("A_gnt_after", 32'(sif.gnt), 32'd0);

    // Zero-step grant goes straight to DONE without touching Yt.
    set_in(2'b10, 0, 0, 1'b0);
    nclk(1);
    chk("B0_gnt", 32'(sif.gnt), 32'h2);
    chk("B0_done", 32'(sif.done), 32'd1);
    chk("B0_t_in", 32'(sif.t_in), 32'd0);
    set_in(2'b00, 0, 0, 1'b0);
    nclk(1);

    // Three steps to Yt=3 with steps changed mid-run, then two more steps.
    set_in(2'b10, 0, 3, 1'b0);
    nclk(1);
    set_in(2'b10, 0, 7, 1'b0);
    nclk(3);
    chk("B1_done", 32'(sif.done), 32'd1);
    chk("B1_Yt", 32'(sif.Yt), 32'd3);
    set_in(2'b00, 0, 0, 1'b0);
    nclk(1);
    set_in(2'b01, 2, 0, 1'b0);
    nclk(1);
    chk("B2_t_in_3to7", 32'(sif.t_in), 32'h4);
    nclk(1);
    chk("B2_Yt", 32'(sif.Yt), 32'd7);
    chk("B2_t_in_7to2", 32'(sif.t_in), 32'h5);
    nclk(1);
    chk("B2_Yt_end", 32'(sif.Yt), 32'd2);
    set_in(2'b00, 0, 0, 1'b0);
    nclk(1);

    // Clear with a grant in IDLE: Yt restarts at 0, clear ignored once running.
    set_in(2'b01, 1, 0, 1'b1);
    nclk(1);
    chk("C_Yt_clr", 32'(sif.Yt), 32'd0);
    chk("C_gnt", 32'(sif.gnt), 32'h1);
    nclk(1);
    chk("C_Yt_run", 32'(sif.Yt), 32'd8);
    set_in(2'b00, 0, 0, 1'b0);
    nclk(1);

    // Both requesting from reset: requester 0 first, then strict alternation.
    do_reset();
    set_in(2'b11, 1, 1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      nclk(1);
      if (sif.done) c_gnt.push_back(sif.gnt);
    end
    chk("D_ndone", 32'(c_gnt.size()), 32'd4);
    for (int k = 0; k < c_gnt.size() && k < 4; k++)
      chk("D_gnt_order", 32'(c_gnt[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
    set_in(2'b00, 0, 0, 1'b0);
    nclk(2);

    // Reset in the third RUN cycle clears everything immediately.
    do_reset();
    set_in(2'b01, 5, 0, 1'b0);
    nclk(3);
    chk("E_Yt_pre", 32'(sif.Yt), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("E_Yt",   32'(sif.Yt),   32'd0);
    chk("E_gnt",  32'(sif.gnt),  32'd0);
    chk("E_busy", 32'(sif.busy), 32'd0);
    chk("E_done", 32'(sif.done), 32'd0);
    set_in(2'b00, 0, 0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    nclk(3);

    // Randomized traffic; requesters usually drop on their done, sometimes keep requesting.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      r = sif.req;
      for (int i = 0; i < 2; i++) begin
        if (r[i] && sif.done && sif.gnt[i]) begin
          if ($urandom_range(3) != 0) r[i] = 1'b0;
        end else if (!r[i] && $urandom_range(2) == 0) begin
          r[i] = 1'b1;
        end
      end
      set_in(r, int'($urandom_range(7)), int'($urandom_range(7)), ($urandom_range(7) == 0));
      if (cyc % 700 == 350) begin
        #3 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
      end
    end

    set_in(2'b00, 0, 0, 1'b0);
    nclk(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen_scheduler.md
SEQ_GEN_SCHEDULER -- requirements
Module: seq_gen_scheduler

Interface
REQ-001 Parameter CNT_W, default 3: width of each requester's step-count field.
REQ-002 Port clock  input  1: single clock, all state on rising edge.
REQ-003 Port reset_n  input  1: reset, asynchronous, active-low.
REQ-004 Port req  input  2: per-requester request, level, bit i = requester i.
REQ-005 Port steps0  input  CNT_W: step count for requester 0, sampled at grant.
REQ-006 Port steps1  input  CNT_W: step count for requester 1, sampled at grant.
REQ-007 Port clear  input  1: synchronous reset of the sequence register to 0, honoured in IDLE only.
REQ-008 Port gnt  output  2: one-hot grant, registered.
REQ-009 Port busy  output  1: high in RUN and DONE.
REQ-010 Port done  output  1: one-cycle pulse ending a grant.
REQ-011 Port Yt  output  4: present state of the T-flip-flop sequence register.
REQ-012 Port Yt1  output  4: next state of the sequence, combinational from Yt.
REQ-013 Port t_in  output  4: toggle vector applied to the T flip-flops, combinational.

Function
REQ-014 Sequence register is four T flip-flops; the legal cycle is 0 -> 8 -> 5 -> 3 -> 7 -> 2 -> 0.
REQ-015 Yt1 is the successor of Yt per REQ-014; any illegal Yt (1,4,6,9-15) has Yt1 = 0.
REQ-016 t_in = Yt XOR Yt1 in RUN, else 4'b0000; the register toggles bit k when t_in[k]=1.
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: req=00 -> stay in IDLE; gnt=00.
REQ-019 IDLE with request: winner chosen round-robin, the requester not served last wins a tie; a sole requester always wins.
REQ-020 Grant edge: gnt set one-hot to the winner, the winner's steps latched into a CNT_W-bit remaining counter, last-served updated.
REQ-021 Grant with latched count nonzero -> RUN; count zero -> DONE directly, no advance.
REQ-022 RUN: each cycle Yt advances one step and remaining decrements; the edge that brings remaining to 0 enters DONE; N steps = exactly N RUN cycles.
REQ-023 DONE: done=1 and gnt held for one cycle, then gnt=00 and state IDLE.
REQ-024 Request latency: req sampled high in IDLE -> gnt high at the next edge; after DONE, IDLE lasts at least one cycle before the next grant.
REQ-025 Requester drops req on seeing done; a req still high in IDLE is a new request.
REQ-026 steps0/steps1 changes after the grant edge have no effect on the current run.
REQ-027 Yt holds its value between runs; each run continues from the current position.
REQ-028 clear in IDLE sets Yt=0 at the next edge and takes precedence over a simultaneous grant; the grant still proceeds in the same cycle. clear outside IDLE is ignored.

Reset
REQ-029 reset_n low asynchronously forces state=IDLE, Yt=0, gnt=00, busy=0, done=0, remaining=0, last-served=requester 1, independent of clock.
REQ-030 Reset mid-RUN aborts the run with no done pulse; operation resumes from IDLE on the first edge after reset_n rises.

Verification
REQ-031 Reset, req=01, steps0=6 -> gnt=01; Yt 0,8,5,3,7,2,0 over 6 RUN cycles; done one cycle; gnt=00 after.
REQ-032 Reset, req=11 in the same cycle -> requester 0 served first, then requester 1 after its IDLE gap.
REQ-033 req=10, steps1=0 -> gnt=10, DONE next cycle, Yt unchanged, t_in=0 throughout.
REQ-034 req=10, steps1=3 from Yt=0 -> Yt=3; then req=01, steps0=2 -> Yt=7 then 2; t_in=4'b0100 on the 3->7 step and 4'b0101 on the 7->2 step.
REQ-035 Reset asserted in the third RUN cycle -> Yt, gnt, busy, done all 0 immediately; no done pulse.
REQ-036 req=11 held continuously, steps0=steps1=1 -> grants alternate 01,10,01,10 with exactly one done per grant.
